// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame receiver.
package uart_frame_pkg;

  // Decoder states: hunt for sync, collect length/payload/checksum, then drain.
  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_GET_LEN = 3'd1,
    ST_GET_PAY = 3'd2,
    ST_GET_CHK = 3'd3,
    ST_DRAIN   = 3'd4
  } frame_state_t;

  // Default frame start marker.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Width of the running checksum (modulo-256 sum).
  localparam int unsigned CHK_W = 8;

  typedef logic [CHK_W-1:0] chk_t;

  // Modulo-256 checksum accumulate; the carry out is dropped on purpose.
  function automatic chk_t chk_add(input chk_t acc, input logic [7:0] b);
    chk_t res;
    res = acc + b;
    return res;
  endfunction

endpackage

// File: rtl/uart_frame_rx_counter.sv
// Free-running clearable up-counter used as the inter-byte idle timer.
module uart_frame_rx_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority over increment, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame decoder: SYNC, LEN, LEN payload bytes, CHK = (LEN + sum payload) mod 256.
// A validated payload is drained over a valid/ready byte stream with a last flag;
// bad length, bad checksum, mid-frame idle gaps and bytes arriving while draining
// are reported as one-cycle registered error pulses.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned TIMEOUT   = 52083
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       crc_err,
  output logic       len_err,
  output logic       timeout_err,
  output logic       overrun_err
);

  localparam int unsigned IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  frame_state_t state_q, state_d;

  logic [7:0] len_q, len_d;
  chk_t       sum_q, sum_d;
  logic [7:0] wr_idx_q, wr_idx_d;
  logic [7:0] rd_idx_q, rd_idx_d;

  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       crc_err_q, crc_err_d;
  logic       len_err_q, len_err_d;
  logic       timeout_err_q, timeout_err_d;
  logic       overrun_err_q, overrun_err_d;

  // Payload storage; deliberately not reset, only read inside a validated frame.
  logic [7:0] buf_q [MAX_LEN];
  logic       buf_we;

  logic [CNT_W-1:0] idle_cnt;
  logic             mid_frame;
  logic             tmo_hit;
  logic             cnt_clr;
  logic             len_ok;
  logic             xfer;
  logic [7:0]       rd_nxt;
  chk_t             sum_add;

  assign mid_frame = (state_q == ST_GET_LEN) || (state_q == ST_GET_PAY) ||
                     (state_q == ST_GET_CHK);
  // A byte in the same cycle always wins over the timeout.
  assign tmo_hit   = mid_frame && !byte_valid && (idle_cnt == TMO_LAST);
  // Idle timer only runs mid-frame; holding it at zero elsewhere also clears it on entry.
  assign cnt_clr   = byte_valid || !mid_frame || tmo_hit;
  assign len_ok    = (byte_in != 8'd0) && (byte_in <= MAX_LEN_B);
  assign xfer      = out_valid_q && out_ready;
  assign rd_nxt    = rd_idx_q + 8'd1;
  assign sum_add   = chk_add(sum_q, byte_in);

  uart_frame_rx_counter #(
    .W (CNT_W)
  ) u_idle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (mid_frame),
    .count (idle_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one transition per accepted byte, or on idle timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT: begin
        if (byte_valid && (byte_in == SYNC_BYTE)) begin
          state_d = ST_GET_LEN;
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_GET_LEN: begin
        if (byte_valid) begin
          if (len_ok) begin
            state_d = ST_GET_PAY;
          end else begin
            state_d = ST_HUNT;
          end
        end else if (tmo_hit) begin
          state_d = ST_HUNT;
        end else begin
          state_d = ST_GET_LEN;
        end
      end
      ST_GET_PAY: begin
        if (byte_valid) begin
          if (wr_idx_q == (len_q - 8'd1)) begin
            state_d = ST_GET_CHK;
          end else begin
            state_d = ST_GET_PAY;
          end
        end else if (tmo_hit) begin
          state_d = ST_HUNT;
        end else begin
          state_d = ST_GET_PAY;
        end
      end
      ST_GET_CHK: begin
        if (byte_valid) begin
          if (byte_in == sum_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_HUNT;
          end
        end else if (tmo_hit) begin
          state_d = ST_HUNT;
        end else begin
          state_d = ST_GET_CHK;
        end
      end
      ST_DRAIN: begin
        if (xfer && out_last_q) begin
          state_d = ST_HUNT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  // Datapath and output next values; outputs are precomputed so they leave flops.
  always_comb begin
    len_d         = len_q;
    sum_d         = sum_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    crc_err_d     = 1'b0;
    len_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    overrun_err_d = 1'b0;
    buf_we        = 1'b0;
    case (state_q)
      ST_HUNT: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
      ST_GET_LEN: begin
        if (byte_valid) begin
          if (len_ok) begin
            len_d    = byte_in;
            sum_d    = byte_in;
            wr_idx_d = 8'd0;
          end else begin
            len_err_d = 1'b1;
          end
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
        end else begin
          len_d = len_q;
        end
      end
      ST_GET_PAY: begin
        if (byte_valid) begin
          buf_we   = 1'b1;
          sum_d    = sum_add;
          wr_idx_d = wr_idx_q + 8'd1;
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
        end else begin
          sum_d = sum_q;
        end
      end
      ST_GET_CHK: begin
        if (byte_valid) begin
          if (byte_in == sum_q) begin
            rd_idx_d    = 8'd0;
            out_valid_d = 1'b1;
            out_data_d  = buf_q[0];
            out_last_d  = (len_q == 8'd1);
          end else begin
            crc_err_d = 1'b1;
          end
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
        end else begin
          sum_d = sum_q;
        end
      end
      ST_DRAIN: begin
        // Bytes arriving while draining are dropped, sync included.
        overrun_err_d = byte_valid;
        if (xfer) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = 8'd0;
          end else begin
            rd_idx_d   = rd_nxt;
            out_data_d = buf_q[rd_nxt[IDX_W-1:0]];
            out_last_d = (rd_nxt == (len_q - 8'd1));
          end
        end else begin
          out_data_d = out_data_q;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset aborts any frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q         <= 8'd0;
      sum_q         <= '0;
      wr_idx_q      <= 8'd0;
      rd_idx_q      <= 8'd0;
      out_data_q    <= 8'd0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      crc_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      len_q         <= len_d;
      sum_q         <= sum_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      crc_err_q     <= crc_err_d;
      len_err_q     <= len_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // Payload buffer write port.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[wr_idx_q[IDX_W-1:0]] <= byte_in;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign crc_err     = crc_err_q;
  assign len_err     = len_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed vector table, hand-written
// timing sequences and randomized frames checked against a frame-level model.
module tb_uart_frame_rx;

  localparam int MAXL = 16;
  localparam int TMO  = 40;

  logic       clk;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       crc_err;
  logic       len_err;
  logic       timeout_err;
  logic       overrun_err;

  uart_frame_rx #(
    .SYNC_BYTE (8'hA5),
    .MAX_LEN   (MAXL),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .crc_err     (crc_err),
    .len_err     (len_err),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_crc = 0, exp_len = 0, exp_tmo = 0, exp_ovr = 0;
  bit rand_mode = 1'b0;

  // monitor state
  logic [8:0] got_q[$];
  int got_rd = 0;
  int n_crc = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
  int stall_viol = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic prev_last = 1'b0;

  logic [8:0] exp_q[$];

  typedef struct {
    logic [0:7][7:0] bytes;
    int              n;
    logic [0:3][7:0] exp;
    int              n_exp;
    int              e_crc;
    int              e_len;
  } vec_t;
  vec_t vecs[7];

  // Output monitor: collects transfers, counts error-pulse cycles, checks stall hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data != prev_data || out_last != prev_last))
        stall_viol <= stall_viol + 1;
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
      prev_last  <= out_last;
      if (crc_err)     n_crc <= n_crc + 1;
      if (len_err)     n_len <= n_len + 1;
      if (timeout_err) n_tmo <= n_tmo + 1;
      if (overrun_err) n_ovr <= n_ovr + 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) tick();
    send_byte(b);
  endtask

  task automatic sync_got();
    got_rd = got_q.size();
  endtask

  task automatic check_stream(input string tag);
    check_eq({tag, "_count"}, got_q.size() - got_rd, exp_q.size());
    foreach (exp_q[i]) begin
      if (got_rd + i < got_q.size()) begin
        check_eq({tag, "_data"}, int'(got_q[got_rd+i][7:0]), int'(exp_q[i][7:0]));
        check_eq({tag, "_last"}, int'(got_q[got_rd+i][8]), int'(exp_q[i][8]));
      end
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic check_errs(input string tag);
    check_eq({tag, "_crc_err"}, n_crc, exp_crc);
    check_eq({tag, "_len_err"}, n_len, exp_len);
    check_eq({tag, "_timeout_err"}, n_tmo, exp_tmo);
    check_eq({tag, "_overrun_err"}, n_ovr, exp_ovr);
  endtask

  task automatic set_vec(input int i, input logic [63:0] b, input int n,
                         input logic [31:0] e, input int ne, input int ec, input int el);
    vecs[i].bytes = b;
    vecs[i].n     = n;
    vecs[i].exp   = e;
    vecs[i].n_exp = ne;
    vecs[i].e_crc = ec;
    vecs[i].e_len = el;
  endtask

  // Randomized frame; expectations come from the frame rules, not the RTL.
  task automatic rand_frame();
    int kind;
    int len;
    int sum;
    logic [7:0] p;
    logic [7:0] chk;
    logic [8:0] loc_q[$];
    kind = $urandom_range(0, 3);
    if (kind <= 1) begin
      len = ($urandom_range(0, 3) == 0) ? MAXL : $urandom_range(1, MAXL);
      sum = len;
      send_gap(8'hA5);
      send_gap(8'(len));
      for (int i = 0; i < len; i++) begin
        p = 8'($urandom_range(0, 255));
        sum = (sum + int'(p)) % 256;
        loc_q.push_back({(i == len - 1), p});
        send_gap(p);
      end
      chk = 8'(sum);
      if (kind == 1) begin
        chk = chk ^ 8'(1 << $urandom_range(0, 7));
        exp_crc++;
      end else begin
        exp_q = loc_q;
      end
      send_gap(chk);
      for (int k = 0; k < 300 && out_valid; k++) tick();
      check_eq("rand_drain_done", out_valid, 0);
    end else if (kind == 2) begin
      send_gap(8'hA5);
      if ($urandom_range(0, 1) == 0) send_gap(8'h00);
      else send_gap(8'($urandom_range(MAXL + 1, 255)));
      exp_len++;
    end else begin
      repeat ($urandom_range(1, 3)) begin
        p = 8'($urandom_range(0, 255));
        if (p == 8'hA5) p = 8'h5A;
        send_gap(p);
      end
    end
    repeat (3) tick();
    check_stream("rand_stream");
    check_errs("rand");
  endtask

  initial begin
    logic [3:0] pat;
    rst = 1'b1; byte_in = 8'd0; byte_valid = 1'b0; out_ready = 1'b1;

    // Directed vectors {bytes, expected payload stream, expected errors}
    set_vec(0, {8'hA5,8'h03,8'h10,8'h20,8'h30,8'h63,8'h00,8'h00}, 6, {8'h10,8'h20,8'h30,8'h00}, 3, 0, 0);
    set_vec(1, {8'hA5,8'h03,8'h10,8'h20,8'h30,8'h64,8'h00,8'h00}, 6, 32'h0, 0, 1, 0);
    set_vec(2, {8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 32'h0, 0, 0, 1);
    set_vec(3, {8'hA5,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 32'h0, 0, 0, 1);
    set_vec(4, {8'hA5,8'h01,8'h7E,8'h7F,8'h00,8'h00,8'h00,8'h00}, 4, {8'h7E,8'h00,8'h00,8'h00}, 1, 0, 0);
    set_vec(5, {8'h3C,8'hA5,8'h02,8'h01,8'hFF,8'h02,8'h00,8'h00}, 6, {8'h01,8'hFF,8'h00,8'h00}, 2, 0, 0);
    set_vec(6, {8'hA5,8'hA5,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 32'h0, 0, 0, 1);

    repeat (3) tick();
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_out_data", out_data, 0);
    check_eq("reset_out_last", out_last, 0);
    check_eq("reset_errs", {crc_err, len_err, timeout_err, overrun_err}, 0);
    rst = 1'b0;
    tick();
    check_eq("idle_out_valid", out_valid, 0);

    // Table-driven vectors
    for (int v = 0; v < 7; v++) begin
      sync_got();
      for (int j = 0; j < vecs[v].n; j++) begin
        send_byte(vecs[v].bytes[j]);
        tick();
      end
      repeat (10) tick();
      for (int j = 0; j < vecs[v].n_exp; j++)
        exp_q.push_back({(j == vecs[v].n_exp - 1), vecs[v].exp[j]});
      exp_crc += vecs[v].e_crc;
      exp_len += vecs[v].e_len;
      check_stream("vec_stream");
      check_errs("vec");
    end

    // Exact latency, back-to-back drain, SYNC accepted right after last transfer
    sync_got();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    send_byte(8'h63);
    check_eq("lat_valid0", out_valid, 1);
    check_eq("lat_data0", out_data, 8'h10);
    check_eq("lat_last0", out_last, 0);
    tick();
    check_eq("lat_data1", out_data, 8'h20);
    check_eq("lat_last1", out_last, 0);
    tick();
    check_eq("lat_data2", out_data, 8'h30);
    check_eq("lat_last2", out_last, 1);
    tick();
    check_eq("lat_valid_end", out_valid, 0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    check_eq("resync_valid", out_valid, 1);
    check_eq("resync_data", out_data, 8'h7E);
    check_eq("resync_last", out_last, 1);
    tick();
    check_eq("resync_valid_end", out_valid, 0);
    sync_got();
    check_errs("lat");

    // Timeout fires exactly once, TIMEOUT cycles after the last byte
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
    for (int n = 1; n <= 41; n++) begin
      tick();
      if (n == 39) check_eq("tmo_early", timeout_err, 0);
      if (n == 40) check_eq("tmo_pulse", timeout_err, 1);
      if (n == 41) check_eq("tmo_single", timeout_err, 0);
    end
    exp_tmo++;
    check_errs("tmo");

    // Byte on the TIMEOUT-1 cycle suppresses the timeout
    sync_got();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
    repeat (39) tick();
    send_byte(8'hBB);
    send_byte(8'h67);
    repeat (5) tick();
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b1, 8'hBB});
    check_stream("tmo_race_stream");
    check_errs("tmo_race");

    // Stalled drain with an overrun byte (a SYNC) in the middle
    sync_got();
    pat = 4'b1001;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h0E);
    for (int k = 0; k < 40 && !((got_q.size() - got_rd >= 4) && !out_valid); k++) begin
      out_ready = pat[k % 4];
      if (k == 2) begin
        byte_in    = 8'hA5;
        byte_valid = 1'b1;
      end else begin
        byte_valid = 1'b0;
      end
      tick();
    end
    byte_valid = 1'b0;
    out_ready  = 1'b1;
    repeat (3) tick();
    exp_ovr++;
    for (int i = 1; i <= 4; i++) exp_q.push_back({(i == 4), 8'(i)});
    check_stream("stall_stream");
    check_errs("stall");

    // Reset mid-payload
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("rst_pay_valid", out_valid, 0);
    repeat (60) tick();
    check_errs("rst_pay");
    sync_got();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h33); send_byte(8'h44); send_byte(8'h79);
    repeat (4) tick();
    exp_q.push_back({1'b0, 8'h33});
    exp_q.push_back({1'b1, 8'h44});
    check_stream("rst_pay_stream");

    // Reset mid-drain
    out_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h09);
    tick();
    check_eq("rst_drn_pre_valid", out_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("rst_drn_valid", out_valid, 0);
    check_eq("rst_drn_last", out_last, 0);
    check_eq("rst_drn_data", out_data, 0);
    out_ready = 1'b1;
    repeat (5) tick();
    check_stream("rst_drn_empty");
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55); send_byte(8'h56);
    repeat (3) tick();
    exp_q.push_back({1'b1, 8'h55});
    check_stream("rst_drn_stream");
    check_errs("rst_drn");

    // Randomized frames against the frame-level model
    rand_mode = 1'b1;
    for (int f = 0; f < 40; f++) rand_frame();
    rand_mode = 1'b0;
    out_ready = 1'b1;

    check_eq("stall_hold", stall_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
